mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 13 +
 rtl/mem_access_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the data-memory access stage.
// The FSM encoding and the default access timeout live here.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RESP
  } mau_state_e;

  localparam int MEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_access_unit.sv
// MEM stage: issues load/store requests over a valid/ready channel,
// stalls upstream until completion and flags misalignment/timeouts.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memToRegInput,
  input  logic        regWriteInput,
  input  logic        memWriteInput,
  input  logic        memReadInput,
  input  logic [31:0] aluResultInput,
  input  logic [4:0]  regWriteAddressInput,
  input  logic [31:0] memWriteDataInput,
  output logic        memReqValid,
  input  logic        memReqReady,
  output logic        memReqWrite,
  output logic [31:0] memReqAddress,
  output logic [31:0] memReqWriteData,
  input  logic        memRespValid,
  input  logic [31:0] memRespReadData,
  output logic        stallOutput,
  output logic        memToRegOutput,
  output logic        regWriteOutput,
  output logic [31:0] aluResultOutput,
  output logic [31:0] readDataOutput,
  output logic [4:0]  regWriteAddressOutput,
  output logic        alignErrorOutput,
  output logic        busErrorOutput
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

  mau_state_e  r_state;
  mau_state_e  w_next;
  logic        r_memToReg;
  logic        r_regWrite;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;
  logic [7:0]  r_cnt;
  logic        w_memop;
  logic        w_aligned;
  logic        w_timeout;

  always_comb begin
    w_memop         = memReadInput | memWriteInput;
    w_aligned       = (aluResultInput[1:0] == 2'b00);
    w_timeout       = (r_cnt == LP_TIMEOUT);
    w_next          = r_state;
    stallOutput     = 1'b0;
    memReqValid     = 1'b0;
    memReqWrite     = r_write;
    memReqAddress   = r_addr;
    memReqWriteData = r_wdata;
    unique case (r_state)
      ST_IDLE: begin
        if (w_memop && w_aligned) begin
          stallOutput = 1'b1;
          w_next      = ST_REQ;
        end
      end
      ST_REQ: begin
        // acceptance wins over a coincident timeout
        if (memReqReady) begin
          memReqValid = 1'b1;
          if (r_write) begin
            w_next = ST_IDLE;
          end else begin
            stallOutput = 1'b1;
            w_next      = ST_WAIT_RESP;
          end
        end else if (w_timeout) begin
          w_next = ST_IDLE;
        end else begin
          memReqValid = 1'b1;
          stallOutput = 1'b1;
        end
      end
      ST_WAIT_RESP: begin
        if (memRespValid || w_timeout) begin
          w_next = ST_IDLE;
        end else begin
          stallOutput = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (reset) begin
      stallOutput = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state               <= ST_IDLE;
      r_cnt                 <= '0;
      r_memToReg            <= 1'b0;
      r_regWrite            <= 1'b0;
      r_write               <= 1'b0;
      r_addr                <= '0;
      r_wdata               <= '0;
      r_rd                  <= '0;
      memToRegOutput        <= 1'b0;
      regWriteOutput        <= 1'b0;
      aluResultOutput       <= '0;
      readDataOutput        <= '0;
      regWriteAddressOutput <= '0;
      alignErrorOutput      <= 1'b0;
      busErrorOutput        <= 1'b0;
    end else begin
      r_state               <= w_next;
      memToRegOutput        <= 1'b0;
      regWriteOutput        <= 1'b0;
      aluResultOutput       <= '0;
      readDataOutput        <= '0;
      regWriteAddressOutput <= '0;
      alignErrorOutput      <= 1'b0;
      busErrorOutput        <= 1'b0;
      if (r_state != ST_IDLE) begin
        r_cnt <= r_cnt + 8'd1;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (!w_memop) begin
            memToRegOutput        <= memToRegInput;
            regWriteOutput        <= regWriteInput;
            aluResultOutput       <= aluResultInput;
            regWriteAddressOutput <= regWriteAddressInput;
          end else if (w_aligned) begin
            r_cnt      <= '0;
            r_memToReg <= memToRegInput;
            r_regWrite <= regWriteInput;
            r_write    <= memWriteInput;
            r_addr     <= aluResultInput;
            r_wdata    <= memWriteDataInput;
            r_rd       <= regWriteAddressInput;
          end else begin
            alignErrorOutput <= 1'b1;
          end
        end
        ST_REQ: begin
          if (memReqReady) begin
            if (r_write) begin
              memToRegOutput        <= r_memToReg;
              aluResultOutput       <= r_addr;
              regWriteAddressOutput <= r_rd;
            end
          end else if (w_timeout) begin
            busErrorOutput <= 1'b1;
          end
        end
        ST_WAIT_RESP: begin
          if (memRespValid) begin
            memToRegOutput        <= r_memToReg;
            regWriteOutput        <= r_regWrite;
            aluResultOutput       <= r_addr;
            readDataOutput        <= memRespReadData;
            regWriteAddressOutput <= r_rd;
          end else if (w_timeout) begin
            busErrorOutput <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
